// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit period and FSM state encoding.
// Used by the transmitter and reusable by a receiver.
package uart_pkg;
  localparam int UART_DATA_W      = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;
endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick_o
// for one cycle at terminal count. clr_i restarts the period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_sender.sv
// UART transmitter: 8N1, LSB first, registered line and status outputs.
// Define UART_SENDER_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_sender
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] UART_TXD,
  input  logic                   TX_EN,
  output logic                   TX_STATUS,
  output logic                   UART_TX
);
  uart_state_e            state_q;
  logic [UART_DATA_W-1:0] data_q;
  logic [2:0]             idx_q;
  logic                   tx_q, status_q;
  logic                   accept, tick;

  assign accept    = (state_q == ST_IDLE) && TX_EN;
  assign UART_TX   = tx_q;
  assign TX_STATUS = status_q;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_baud (
    .clk    (clk),
    .rst_ni (reset),
    .clr_i  (accept),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  // tx_q is loaded with the level of the next bit on the edge that enters it,
  // so the line is a pure register with no input-to-output path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      status_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (TX_EN) begin
          data_q   <= UART_TXD;
          idx_q    <= '0;
          tx_q     <= 1'b0;
          status_q <= 1'b0;
          state_q  <= ST_START;
        end
        ST_START: if (tick) begin
          idx_q   <= '0;
          tx_q    <= data_q[0];
          state_q <= ST_DATA;
        end
        ST_DATA: if (tick) begin
          if (idx_q == 3'd7) begin
`ifdef UART_SENDER_PARITY_EN
            tx_q    <= ^data_q;
            state_q <= ST_PARITY;
`else
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
`endif
          end else begin
            idx_q <= idx_q + 3'd1;
            tx_q  <= data_q[idx_q + 3'd1];
          end
        end
`ifdef UART_SENDER_PARITY_EN
        ST_PARITY: if (tick) begin
          tx_q    <= 1'b1;
          state_q <= ST_STOP;
        end
`endif
        ST_STOP: if (tick) begin
          tx_q     <= 1'b1;
          status_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          tx_q     <= 1'b1;
          status_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender with CLKS_PER_BIT=4; inputs and samples on negedge.
// Define UART_SENDER_PARITY_EN to also exercise the parity frame.
module tb_uart_sender;
  localparam int CPB = 4;
`ifdef UART_SENDER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] UART_TXD = 8'h00;
  logic       TX_EN = 1'b0;
  logic       TX_STATUS, UART_TX;
  int         total = 0;
  int         bad = 0;

  uart_sender #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .UART_TXD  (UART_TXD),
    .TX_EN     (TX_EN),
    .TX_STATUS (TX_STATUS),
    .UART_TX   (UART_TX)
  );

  always #5 clk = ~clk;

  // Expected line levels per bit period: start, d0..d7, [parity], stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_SENDER_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic test_reset();
    // reset and TX_EN together: reset wins
    reset = 1'b0; TX_EN = 1'b1; UART_TXD = 8'hAA;
    repeat (2) @(negedge clk);
    total++;
    if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
      bad++; $display("FAIL reset_state tx=%b status=%b want 1/1", UART_TX, TX_STATUS);
    end
    TX_EN = 1'b0; reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
        bad++; $display("FAIL idle_hold cyc=%0d tx=%b status=%b want 1/1", i, UART_TX, TX_STATUS);
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] d, input string nm);
    logic [10:0] f;
    f = exp_frame(d);
    @(negedge clk);
    TX_EN = 1'b1; UART_TXD = d;
    @(negedge clk);
    TX_EN = 1'b0; UART_TXD = ~d;
    for (int i = 0; i < FLEN; i++) begin
      total++;
      if (UART_TX !== f[i/CPB] || TX_STATUS !== 1'b0) begin
        bad++; $display("FAIL %s cyc=%0d tx=%b status=%b want %b/0", nm, i, UART_TX, TX_STATUS, f[i/CPB]);
      end
      @(negedge clk);
    end
    total++;
    if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
      bad++; $display("FAIL %s_end tx=%b status=%b want 1/1", nm, UART_TX, TX_STATUS);
    end
  endtask

  task automatic test_busy_ignore();
    logic [10:0] f;
    f = exp_frame(8'hA3);
    @(negedge clk);
    TX_EN = 1'b1; UART_TXD = 8'hA3;
    @(negedge clk);
    TX_EN = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      total++;
      if (UART_TX !== f[i/CPB] || TX_STATUS !== 1'b0) begin
        bad++; $display("FAIL busy_a3 cyc=%0d tx=%b status=%b want %b/0", i, UART_TX, TX_STATUS, f[i/CPB]);
      end
      if (i == 12) begin TX_EN = 1'b1; UART_TXD = 8'hFF; end
      if (i == 13) TX_EN = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
        bad++; $display("FAIL busy_dropped cyc=%0d tx=%b status=%b want 1/1", i, UART_TX, TX_STATUS);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic       smp [0:119];
    logic [7:0] b;
    int         starts[$];
    logic [7:0] bytes[$];
    bit         sent2, stop_ok;
    int         i;
    sent2 = 1'b0; stop_ok = 1'b1;
    @(negedge clk);
    TX_EN = 1'b1; UART_TXD = 8'h00;
    @(negedge clk);
    TX_EN = 1'b0;
    for (int s = 0; s < 120; s++) begin
      smp[s] = UART_TX;
      if (TX_EN) TX_EN = 1'b0;
      if (!sent2 && TX_STATUS === 1'b1) begin
        total++;
        if (s != FLEN) begin
          bad++; $display("FAIL b2b_status_len first idle at %0d want %0d", s, FLEN);
        end
        TX_EN = 1'b1; UART_TXD = 8'h80; sent2 = 1'b1;
      end
      @(negedge clk);
    end
    // reference receiver: find falling edge, sample each bit mid-period
    i = 0;
    while (i < 120 - FLEN) begin
      if (smp[i] === 1'b0 && (i == 0 || smp[i-1] === 1'b1)) begin
        for (int k = 0; k < 8; k++) b[k] = smp[i + CPB*(k+1) + CPB/2];
        if (smp[i + CPB*(NBITS-1) + CPB/2] !== 1'b1) stop_ok = 1'b0;
        starts.push_back(i); bytes.push_back(b);
        i += FLEN;
      end else i++;
    end
    total++;
    if (starts.size() != 2) begin
      bad++; $display("FAIL b2b_frames got=%0d want 2", starts.size());
    end else begin
      total++;
      if (starts[0] != 0 || starts[1] != FLEN + 1) begin
        bad++; $display("FAIL b2b_starts got=%0d,%0d want 0,%0d", starts[0], starts[1], FLEN + 1);
      end
      total++;
      if (bytes[0] !== 8'h00 || bytes[1] !== 8'h80 || !stop_ok) begin
        bad++; $display("FAIL b2b_data got=%h,%h stop=%b want 00,80 stop=1", bytes[0], bytes[1], stop_ok);
      end
    end
    total++;
    if (smp[FLEN] !== 1'b1) begin
      bad++; $display("FAIL b2b_gap tx=%b want 1", smp[FLEN]);
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] f;
    f = exp_frame(8'h0F);
    @(negedge clk);
    TX_EN = 1'b1; UART_TXD = 8'h0F;
    @(negedge clk);
    TX_EN = 1'b0;
    for (int i = 0; i <= 17; i++) begin
      total++;
      if (UART_TX !== f[i/CPB]) begin
        bad++; $display("FAIL mid_reset_pre cyc=%0d tx=%b want %b", i, UART_TX, f[i/CPB]);
      end
      if (i < 17) @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
      bad++; $display("FAIL mid_reset tx=%b status=%b want 1/1", UART_TX, TX_STATUS);
    end
    reset = 1'b1;
    test_frame(8'h3C, "after_reset_3c");
  endtask

`ifdef UART_SENDER_PARITY_EN
  task automatic test_parity(input logic [7:0] d, input logic pb_exp);
    logic pb;
    int   busy;
    busy = 0; pb = 1'bx;
    @(negedge clk);
    TX_EN = 1'b1; UART_TXD = d;
    @(negedge clk);
    TX_EN = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 9*CPB + CPB/2) pb = UART_TX;
      if (TX_STATUS === 1'b0) busy++;
      @(negedge clk);
    end
    total++;
    if (pb !== pb_exp) begin
      bad++; $display("FAIL parity_bit data=%h got=%b want %b", d, pb, pb_exp);
    end
    total++;
    if (busy != 44) begin
      bad++; $display("FAIL parity_len data=%h got=%0d want 44", d, busy);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame(8'h55, "frame_55");
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_SENDER_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
